// File: rtl/mac_acc.sv
// mac_acc: adds the reducer's two rows into a product, then accumulates products over a framed dot product.
// Latency: 2 cycles from beat acceptance to out_valid (one carry-propagate stage, one accumulate stage).
// Backpressure: a pending unaccepted result stalls both stages and drops in_ready; no beat is lost.
module mac_acc #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      row1,
    input  logic [15:0]      row2,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_cnt,
    output logic             ovf,
    output logic             err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

    // Stage P registers
    logic             r_p_vld;
    logic             r_p_first;
    logic             r_p_last;
    logic [15:0]      r_p_sum;

    // Stage A registers
    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_err;

    // Result registers
    logic             r_out_vld;
    logic [ACC_W-1:0] r_out_acc;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_ovf;
    logic             r_out_err;

    logic             w_adv;
    logic             w_beat;
    logic             w_start;
    logic [15:0]      w_row_sum;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_err_now;
    logic             w_ovf_nxt;
    logic             w_err_nxt;

    // Whole pipeline moves together: it only stalls when a result is waiting for the consumer.
    assign w_adv    = ~r_out_vld | out_ready;
    assign in_ready = w_adv;
    assign w_beat   = w_adv & r_p_vld;

    // The rows of an 8x8 product never sum past 16 bits, so the carry is simply not kept.
    assign w_row_sum = row1 + row2;

    // Stage A datapath: a beat opens a new frame on an explicit first or when no frame is open.
    always_comb begin
        w_start   = r_p_first | (r_state == ST_IDLE);
        w_base    = w_start ? '0 : r_acc;
        w_sum     = {1'b0, w_base} + {{(ACC_W + 1 - 16){1'b0}}, r_p_sum};
        if (w_start) begin
            w_cnt_nxt = CNT_W'(1);
        end else if (&r_cnt) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        // Missing first in IDLE, or a first inside an open frame, are both framing errors.
        w_err_now = ((r_state == ST_IDLE) & ~r_p_first) | ((r_state == ST_ACC) & r_p_first);
        w_ovf_nxt = (w_start ? 1'b0 : r_ovf) | w_sum[ACC_W];
        w_err_nxt = (w_start ? 1'b0 : r_err) | w_err_now;
    end

    // Stage P: register the row sum and frame markers of each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_vld   <= 1'b0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
            r_p_sum   <= '0;
        end else if (w_adv) begin
            r_p_vld <= in_valid;
            if (in_valid) begin
                r_p_first <= in_first;
                r_p_last  <= in_last;
                r_p_sum   <= w_row_sum;
            end
        end
    end

    // Stage A: accumulate, count terms, track sticky flags and the frame-open state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_beat) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            r_err   <= w_err_nxt;
            r_state <= r_p_last ? ST_IDLE : ST_ACC;
        end
    end

    // Result: load on the closing beat; otherwise a handshake (adv with valid set) retires it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_out_acc <= '0;
            r_out_cnt <= '0;
            r_out_ovf <= 1'b0;
            r_out_err <= 1'b0;
        end else if (w_adv) begin
            r_out_vld <= r_p_vld & r_p_last;
            if (r_p_vld & r_p_last) begin
                r_out_acc <= w_sum[ACC_W-1:0];
                r_out_cnt <= w_cnt_nxt;
                r_out_ovf <= w_ovf_nxt;
                r_out_err <= w_err_nxt;
            end
        end
    end

    assign out_valid = r_out_vld;
    assign acc_out   = r_out_acc;
    assign term_cnt  = r_out_cnt;
    assign ovf       = r_out_ovf;
    assign err       = r_out_err;

endmodule

// File: tb/tb_mac_acc.sv
// tb_mac_acc: directed vector table plus hand-written backpressure, overflow and reset sequences.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// A second instance with a 17-bit accumulator covers wrap-around.
module tb_mac_acc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] row1;
    logic [15:0] row2;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] acc_out;
    logic [7:0]  term_cnt;
    logic        ovf;
    logic        err;

    logic        in_ready17;
    logic        out_valid17;
    logic [16:0] acc_out17;
    logic [7:0]  term_cnt17;
    logic        ovf17;
    logic        err17;

    int n_vec;
    int n_err;

    mac_acc #(.ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .row1(row1), .row2(row2), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .term_cnt(term_cnt), .ovf(ovf), .err(err)
    );

    mac_acc #(.ACC_W(17), .CNT_W(8)) dut17 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready17),
        .row1(row1), .row2(row2), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid17), .out_ready(out_ready), .acc_out(acc_out17),
        .term_cnt(term_cnt17), .ovf(ovf17), .err(err17)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [15:0] r1;
        logic [15:0] r2;
        logic        f;
        logic        l;
        logic        e_vld;
        logic [23:0] e_acc;
        logic [7:0]  e_cnt;
        logic        e_ovf;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic v, input logic [15:0] a, input logic [15:0] b,
                                input logic f, input logic l, input logic ev,
                                input logic [23:0] eacc, input logic [7:0] ecnt,
                                input logic eovf, input logic eerr);
        vec_t t;
        t.vld = v; t.r1 = a; t.r2 = b; t.f = f; t.l = l;
        t.e_vld = ev; t.e_acc = eacc; t.e_cnt = ecnt; t.e_ovf = eovf; t.e_err = eerr;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic f, input logic l);
        in_valid = v;
        row1     = a;
        row2     = b;
        in_first = f;
        in_last  = l;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Single-term frame, 4-term frame of 65025,1,100,0 then a back-to-back frame,
        // missing-first error, restart-mid-frame error, then a clean frame clearing err.
        tbl[0]  = mk(1, 16'h00FF, 16'h0F00, 1, 1,  0, 24'h0,      8'd0, 0, 0);
        tbl[1]  = mk(0, 16'h0000, 16'h0000, 0, 0,  1, 24'h000FFF, 8'd1, 0, 0);
        tbl[2]  = mk(1, 16'hFE00, 16'h0001, 1, 0,  0, 24'h0,      8'd0, 0, 0);
        tbl[3]  = mk(1, 16'h0001, 16'h0000, 0, 0,  0, 24'h0,      8'd0, 0, 0);
        tbl[4]  = mk(1, 16'h0040, 16'h0024, 0, 0,  0, 24'h0,      8'd0, 0, 0);
        tbl[5]  = mk(1, 16'h0000, 16'h0000, 0, 1,  0, 24'h0,      8'd0, 0, 0);
        tbl[6]  = mk(1, 16'h0005, 16'h0007, 1, 0,  1, 24'd65126,  8'd4, 0, 0);
        tbl[7]  = mk(1, 16'h0003, 16'h0000, 0, 1,  0, 24'h0,      8'd0, 0, 0);
        tbl[8]  = mk(0, 16'h0000, 16'h0000, 0, 0,  1, 24'd15,     8'd2, 0, 0);
        tbl[9]  = mk(0, 16'h0000, 16'h0000, 0, 0,  0, 24'h0,      8'd0, 0, 0);
        tbl[10] = mk(1, 16'd10,   16'h0000, 0, 0,  0, 24'h0,      8'd0, 0, 0);
        tbl[11] = mk(1, 16'd20,   16'h0000, 0, 1,  0, 24'h0,      8'd0, 0, 0);
        tbl[12] = mk(0, 16'h0000, 16'h0000, 0, 0,  1, 24'd30,     8'd2, 0, 1);
        tbl[13] = mk(1, 16'd100,  16'h0000, 1, 0,  0, 24'h0,      8'd0, 0, 0);
        tbl[14] = mk(1, 16'd200,  16'h0000, 0, 0,  0, 24'h0,      8'd0, 0, 0);
        tbl[15] = mk(1, 16'd7,    16'h0000, 1, 0,  0, 24'h0,      8'd0, 0, 0);
        tbl[16] = mk(1, 16'd8,    16'h0000, 0, 1,  0, 24'h0,      8'd0, 0, 0);
        tbl[17] = mk(0, 16'h0000, 16'h0000, 0, 0,  1, 24'd15,     8'd2, 0, 1);
        tbl[18] = mk(1, 16'h1234, 16'h0001, 1, 1,  0, 24'h0,      8'd0, 0, 0);
        tbl[19] = mk(0, 16'h0000, 16'h0000, 0, 0,  1, 24'h001235, 8'd1, 0, 0);

        // Reset state
        step();
        step();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst acc_out",   32'(acc_out),   32'd0);
        chk("rst term_cnt",  32'(term_cnt),  32'd0);
        chk("rst ovf",       32'(ovf),       32'd0);
        chk("rst err",       32'(err),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst in_ready",  32'(in_ready),  32'd1);

        // Table vectors
        step();
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].vld, tbl[i].r1, tbl[i].r2,
                  tbl[i].vld & tbl[i].f, tbl[i].vld & tbl[i].l);
            step();
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                chk($sformatf("v%0d acc_out", i),  32'(acc_out),  32'(tbl[i].e_acc));
                chk($sformatf("v%0d term_cnt", i), 32'(term_cnt), 32'(tbl[i].e_cnt));
                chk($sformatf("v%0d ovf", i),      32'(ovf),      32'(tbl[i].e_ovf));
                chk($sformatf("v%0d err", i),      32'(err),      32'(tbl[i].e_err));
            end
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();

        // Backpressure: result 50+60 pending, next beats held on the input.
        out_ready = 1'b0;
        drive(1'b1, 16'd50, 16'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'd60, 16'd0, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'd9, 16'd0, 1'b1, 1'b1);
        step();
        chk("bp out_valid", 32'(out_valid), 32'd1);
        chk("bp acc_out",   32'(acc_out),   32'd110);
        chk("bp term_cnt",  32'(term_cnt),  32'd2);
        drive(1'b1, 16'd4, 16'd0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp stall%0d in_ready", k), 32'(in_ready), 32'd0);
            step();
            chk($sformatf("bp stall%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp stall%0d acc_out", k),   32'(acc_out),   32'd110);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("bp next out_valid", 32'(out_valid), 32'd1);
        chk("bp next acc_out",   32'(acc_out),   32'd9);
        chk("bp next term_cnt",  32'(term_cnt),  32'd1);
        step();
        chk("bp held out_valid", 32'(out_valid), 32'd1);
        chk("bp held acc_out",   32'(acc_out),   32'd4);
        step();
        chk("bp drain out_valid", 32'(out_valid), 32'd0);

        // Overflow on the 17-bit instance: 3 x 65025 wraps to 64003.
        drive(1'b1, 16'hFE00, 16'h0001, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'hFE00, 16'h0001, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'hFE00, 16'h0001, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'h0001, 16'h0000, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("ovf17 out_valid", 32'(out_valid17), 32'd1);
        chk("ovf17 acc_out",   32'(acc_out17),   32'd64003);
        chk("ovf17 term_cnt",  32'(term_cnt17),  32'd3);
        chk("ovf17 ovf",       32'(ovf17),       32'd1);
        chk("ovf24 ovf",       32'(ovf),         32'd0);
        chk("ovf24 acc_out",   32'(acc_out),     32'd195075);
        step();
        chk("ovf17 next acc_out", 32'(acc_out17), 32'd1);
        chk("ovf17 next ovf",     32'(ovf17),     32'd0);
        step();

        // Asynchronous reset with a result pending and a frame open.
        out_ready = 1'b0;
        drive(1'b1, 16'd11, 16'd0, 1'b1, 1'b1);
        step();
        drive(1'b1, 16'd5, 16'd0, 1'b1, 1'b0);
        step();
        chk("ar pre out_valid", 32'(out_valid), 32'd1);
        chk("ar pre acc_out",   32'(acc_out),   32'd11);
        #2;
        rst = 1'b1;
        #1;
        chk("ar out_valid", 32'(out_valid), 32'd0);
        chk("ar acc_out",   32'(acc_out),   32'd0);
        chk("ar term_cnt",  32'(term_cnt),  32'd0);
        chk("ar in_ready",  32'(in_ready),  32'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("ar idle out_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 16'd30, 16'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'd40, 16'd0, 1'b0, 1'b1);
        step();
        chk("ar mid out_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        chk("ar post out_valid", 32'(out_valid), 32'd1);
        chk("ar post acc_out",   32'(acc_out),   32'd70);
        chk("ar post term_cnt",  32'(term_cnt),  32'd2);
        chk("ar post err",       32'(err),       32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
